uart_byte_receiver: RTL and testbench

- UART receiver for one byte per frame: 8N1 format, LSB first, idle-high line.
- Samples the serial input at the centre of each bit using a clock-divided bit timer.
- Presents the received byte with a one-cycle done strobe and a busy flag.
- Sits between the board rs232_rx pin and byte-level protocol logic, such as a Modbus RTU frame assembler.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_timer.sv | 47 ++++
 rtl/uart_byte_receiver.sv | 136 +++++++++++++
 tb/tb_uart_byte_receiver.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the
// 2-of-3 vote helper used when UART_RX_MAJORITY_EN is defined.
package uart_pkg;

    localparam int DATA_BITS   = 8;
    localparam int SYNC_STAGES = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-slot timer: counts 0..BIT_CNT-1 and wraps. Flags the sample point
// (HALF_CNT-1+MID_DELAY) and the last cycle of each slot.
module uart_baud_timer #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int MID_DELAY = 0
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic clear,
    input  logic enable,
    output logic mid_tick,
    output logic end_tick
);

    localparam int BIT_CNT  = CLK_FREQ / BAUD_RATE;
    localparam int HALF_CNT = BIT_CNT / 2;
    localparam int CNT_W    = $clog2(BIT_CNT);

    localparam logic [CNT_W-1:0] MID_VAL = CNT_W'(HALF_CNT - 1 + MID_DELAY);
    localparam logic [CNT_W-1:0] END_VAL = CNT_W'(BIT_CNT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == END_VAL) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // NOTE: non-blocking assignments in clocked blocks, so every flop sees pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mid_tick = enable && (cnt_q == MID_VAL);
    assign end_tick = enable && (cnt_q == END_VAL);

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART byte receiver, LSB first, centre-sampled. Define UART_RX_MAJORITY_EN
// to take each bit as the 2-of-3 vote around the centre instead of one sample.
module uart_byte_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rs232_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_state
);

    logic [SYNC_STAGES:0]   sync_q, sync_d;
    logic [1:0]             state_q, state_d;
    logic [3:0]             bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_done_q, rx_done_d;
    logic                   s2, s3, start_det, bit_val;
    logic                   mid_tick, end_tick, timer_clear, timer_enable;

    assign sync_d    = {sync_q[SYNC_STAGES-1:0], rs232_rx};
    assign s2        = sync_q[SYNC_STAGES-1];
    assign s3        = sync_q[SYNC_STAGES];
    assign start_det = s3 & ~s2;

`ifdef UART_RX_MAJORITY_EN
    localparam int MID_DELAY = 1;
    logic [1:0] hist_q, hist_d;

    // At the decision cycle hist_q holds s2 from the two preceding cycles.
    assign hist_d  = {hist_q[0], s2};
    assign bit_val = majority3(hist_q[1], hist_q[0], s2);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    localparam int MID_DELAY = 0;
    assign bit_val = s2;
`endif

    // The counter is held at zero while idle so the start-detect cycle is count 0.
    assign timer_clear  = (state_d == ST_IDLE);
    assign timer_enable = (state_q != ST_IDLE) | start_det;

    uart_baud_timer #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .MID_DELAY (MID_DELAY)
    ) u_baud_timer (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .clear    (timer_clear),
        .enable   (timer_enable),
        .mid_tick (mid_tick),
        .end_tick (end_tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        rx_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_det) begin
                    state_d   = ST_START;
                    bit_idx_d = 4'd0;
                end
            end
            ST_START: begin
                if (mid_tick && bit_val) begin
                    state_d = ST_IDLE;
                end else if (end_tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = bit_idx_q + 4'd1;
                end
            end
            ST_DATA: begin
                if (mid_tick) begin
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                end
                if (end_tick) begin
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q == 4'(DATA_BITS)) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                // Leaving at the stop-bit centre lets the next start edge follow immediately.
                if (mid_tick) begin
                    state_d = ST_IDLE;
                    if (bit_val) begin
                        rx_data_d = shift_q;
                        rx_done_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_q    <= '1;
            state_q   <= ST_IDLE;
            bit_idx_q <= 4'd0;
            shift_q   <= '0;
            rx_data_q <= '0;
            rx_done_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            rx_done_q <= rx_done_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_done  = rx_done_q;
    assign rx_state = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench for uart_byte_receiver at 50 MHz / 115200 (434 clocks per bit).
module tb_uart_byte_receiver;

    localparam int BIT = 434;
    localparam int FRAME = 10 * BIT;

    logic       clk_in;
    logic       rst_n_in;
    logic       rs232_rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int first_start = 0;
    int width_err = 0;
    int state_err = 0;
    logic done_prev = 1'b0;
    logic [7:0] done_q[$];
    int done_cyc[$];

    uart_byte_receiver dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rs232_rx (rs232_rx),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .rx_state (rx_state)
    );

    initial clk_in = 1'b0;
    always #10 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (rx_done) begin
            done_q.push_back(rx_data);
            done_cyc.push_back(cyc);
            if (rx_state) state_err++;
            if (done_prev) width_err++;
        end
        done_prev = rx_done;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rx_byte(input int i);
        if (i < done_q.size()) return done_q[i];
        return 8'hxx;
    endfunction

    function automatic int done_at(input int i);
        if (i < done_cyc.size()) return done_cyc[i];
        return -1;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // One cycle per drive; spike inverts a single cycle near the centre of each data bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic spike);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < BIT; c++) begin
                @(negedge clk_in);
                if (i == 0 && c == 0) start_cyc = cyc;
                rs232_rx = (spike && i >= 1 && i <= 8 && c == 217) ? ~frame[i] : frame[i];
            end
        end
    endtask

    initial begin
        logic [7:0] b2b[4];
        int lat;
        b2b = '{8'hC2, 8'hB3, 8'hA4, 8'h95};
        rs232_rx = 1'b1;
        rst_n_in = 1'b0;

        wait_cycles(50);
        check("rst_data", {24'd0, rx_data}, 32'h00);
        check("rst_done", {31'd0, rx_done}, 32'd0);
        check("rst_state", {31'd0, rx_state}, 32'd0);
        rst_n_in = 1'b1;
        wait_cycles(20);
        check("rst_release_done_count", done_q.size(), 0);

        send_byte(8'hC2, 1'b1, 1'b0);
        first_start = start_cyc;
        send_byte(8'hB3, 1'b1, 1'b0);
        send_byte(8'hA4, 1'b1, 1'b0);
        send_byte(8'h95, 1'b1, 1'b0);
        wait_cycles(600);
        check("b2b_count", done_q.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("b2b_data%0d", i), {24'd0, rx_byte(i)}, {24'd0, b2b[i]});
        for (int i = 1; i < 4; i++) check($sformatf("b2b_gap%0d", i), done_at(i) - done_at(i - 1), FRAME);
        lat = done_at(0) - first_start;
        check("b2b_latency_window", {31'd0, (lat >= 4124 && lat <= 4127)}, 32'd1);

        rs232_rx = 1'b0;
        wait_cycles(10);
        check("glitch_state_high", {31'd0, rx_state}, 32'd1);
        wait_cycles(90);
        rs232_rx = 1'b1;
        wait_cycles(140);
        check("glitch_state_low", {31'd0, rx_state}, 32'd0);
        wait_cycles(500);
        check("glitch_done_count", done_q.size(), 4);
        check("glitch_data_kept", {24'd0, rx_data}, 32'h95);

        send_byte(8'h55, 1'b0, 1'b0);
        wait_cycles(1000);
        check("frame_err_low_line_idle", {31'd0, rx_state}, 32'd0);
        rs232_rx = 1'b1;
        wait_cycles(200);
        check("frame_err_done_count", done_q.size(), 4);
        check("frame_err_data_kept", {24'd0, rx_data}, 32'h95);
        send_byte(8'hA5, 1'b1, 1'b0);
        wait_cycles(600);
        check("after_ferr_count", done_q.size(), 5);
        check("after_ferr_data", {24'd0, rx_data}, 32'hA5);

        fork
            send_byte(8'h3C, 1'b1, 1'b0);
            begin
                wait_cycles(5 * BIT + 200);
                rst_n_in = 1'b0;
                #1;
                check("midrst_data", {24'd0, rx_data}, 32'h00);
                check("midrst_done", {31'd0, rx_done}, 32'd0);
                check("midrst_state", {31'd0, rx_state}, 32'd0);
            end
        join
        wait_cycles(100);
        rst_n_in = 1'b1;
        wait_cycles(100);
        check("midrst_done_count", done_q.size(), 5);
        send_byte(8'h81, 1'b1, 1'b0);
        wait_cycles(600);
        check("after_rst_count", done_q.size(), 6);
        check("after_rst_data", {24'd0, rx_byte(5)}, 32'h81);

`ifdef UART_RX_MAJORITY_EN
        send_byte(8'h5A, 1'b1, 1'b1);
        wait_cycles(600);
        check("majority_count", done_q.size(), 7);
        check("majority_data", {24'd0, rx_data}, 32'h5A);
`endif

        check("done_width_1cycle", width_err, 0);
        check("state_low_with_done", state_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
